// File: rtl/cpu_pkg.sv
// Shared CPU definitions: LEGv8 condition codes, the NZCV flag struct and
// the condition-field width used by the branch/flag logic.
package cpu_pkg;

   localparam int COND_W = 4;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_HS = 4'd2,
      COND_LO = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Bit order matches the architectural {N,Z,C,V} flag view.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition evaluator: NZCV + condition code -> taken.
// Shared by the branch resolver and any conditional-select logic.
module cond_eval
   import cpu_pkg::*;
(
   input  nzcv_t flags_i,
   input  cond_e cond_i,
   output logic  taken_o
);

   // Decode the condition against the supplied flags.
   always_comb begin
      taken_o = 1'b1;
      case (cond_i)
         COND_EQ: taken_o = flags_i.z;
         COND_NE: taken_o = ~flags_i.z;
         COND_HS: taken_o = flags_i.c;
         COND_LO: taken_o = ~flags_i.c;
         COND_MI: taken_o = flags_i.n;
         COND_PL: taken_o = ~flags_i.n;
         COND_VS: taken_o = flags_i.v;
         COND_VC: taken_o = ~flags_i.v;
         COND_HI: taken_o = flags_i.c & ~flags_i.z;
         COND_LS: taken_o = ~flags_i.c | flags_i.z;
         COND_GE: taken_o = (flags_i.n == flags_i.v);
         COND_LT: taken_o = (flags_i.n != flags_i.v);
         COND_GT: taken_o = ~flags_i.z & (flags_i.n == flags_i.v);
         COND_LE: taken_o = flags_i.z | (flags_i.n != flags_i.v);
         COND_AL: taken_o = 1'b1;
         COND_NV: taken_o = 1'b1;
         default: taken_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV flag register plus B.cond resolution for the ID stage.
// Build option: define FLAG_BYPASS_EN to forward live EX flags into the
// branch evaluation (no stall); leave it undefined to stall one cycle on the
// EX-writes-flags / ID-branch hazard instead.
module flag_cond_unit #(
   parameter int COND_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ex_valid,
   input  logic              ex_set_flags,
   input  logic              ex_negative,
   input  logic              ex_zero,
   input  logic              ex_overflow,
   input  logic              ex_carry_out,
   input  logic              id_br_valid,
   input  logic [COND_W-1:0] id_cond,
   input  logic              flush,
   output logic [3:0]        flags,
   output logic              br_valid,
   output logic              br_taken,
   output logic              stall
);

   import cpu_pkg::*;

   nzcv_t flags_q, flags_d;
   nzcv_t ex_nzcv;
   nzcv_t eval_flags;
   logic  flag_wr;
   logic  resolve;
   logic  cond_taken;
   logic  br_valid_q, br_valid_d;
   logic  br_taken_q, br_taken_d;

   assign flag_wr = ex_valid & ex_set_flags;
   assign ex_nzcv = '{n: ex_negative, z: ex_zero, c: ex_carry_out, v: ex_overflow};

`ifdef FLAG_BYPASS_EN
   // Forward the EX result so a same-cycle branch sees the newest flags.
   assign eval_flags = flag_wr ? ex_nzcv : flags_q;
   assign stall      = 1'b0;
`else
   // No forwarding: hold ID one cycle until the EX write lands in the register.
   assign eval_flags = flags_q;
   assign stall      = id_br_valid & ~flush & flag_wr;
`endif

   cond_eval u_cond_eval (
      .flags_i (eval_flags),
      .cond_i  (cond_e'(id_cond)),
      .taken_o (cond_taken)
   );

   // Next-state: flag write is never gated by flush/stall (EX is older than ID).
   always_comb begin
      flags_d    = flags_q;
      br_valid_d = 1'b0;
      br_taken_d = br_taken_q;
      resolve    = id_br_valid & ~flush & ~stall;
      if (flag_wr) begin
         flags_d = ex_nzcv;
      end
      if (resolve) begin
         br_valid_d = 1'b1;
         br_taken_d = cond_taken;
      end
   end

   // State registers; reset drops any pending branch decision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q    <= '0;
         br_valid_q <= 1'b0;
         br_taken_q <= 1'b0;
      end else begin
         flags_q    <= flags_d;
         br_valid_q <= br_valid_d;
         br_taken_q <= br_taken_d;
      end
   end

   assign flags    = flags_q;
   assign br_valid = br_valid_q;
   assign br_taken = br_taken_q;

endmodule
